hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised per-hart register scoreboard and bypass selector for the multi-hart integer pipeline.
- Tracks destination registers of long-latency ops (loads, external muldiv) until writeback, stalls dependent issue, and forwards same-cycle writeback data.
- Generalises the fixed single-path forwarding to NUM_HARTS harts and NUM_WB writeback ports, and adds stall accounting and an error flag.
- Sits between the decode/issue stage and the register file in cpu_top.

Parameters:
- NUM_HARTS, 2, number of hardware threads; hart id width is `HART_ID_W.
- NUM_WB, 2, writeback ports (port 0 = ALU/LSU, port 1 = muldiv); lower index has higher forwarding priority.
- CNT_W, 32, width of per-hart stall counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue stage presents an instruction.
- iss_hart  in  `HART_ID_W  hart of the issuing instruction.
- iss_rs1, iss_rs2  in  `REG_ADDR_W each  source registers.
- iss_rs1_used, iss_rs2_used  in  1 each  source is actually read.
- iss_rd  in  `REG_ADDR_W  destination register.
- iss_rd_we  in  1  instruction writes rd.
- iss_long  in  1  instruction is long-latency (load or muldiv).
- iss_stall  out  1  hold issue this cycle (combinational).
- rs1_fwd, rs2_fwd  out  1 each  use forwarded data instead of regfile data.
- rs1_fwd_data, rs2_fwd_data  out  `XLEN each  forwarded operand.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_clr  in  NUM_WB  writeback retires a long-latency op (clears pending).
- wb_hart  in  NUM_WB*`HART_ID_W  flattened hart ids.
- wb_rd  in  NUM_WB*`REG_ADDR_W  flattened destinations.
- wb_data  in  NUM_WB*`XLEN  flattened results.
- pending_any  out  NUM_HARTS  hart has at least one pending register (registered).
- stall_cnt  out  NUM_HARTS*CNT_W  per-hart stall-cycle counters.
- sb_err  out  1  sticky: wb_clr hit a non-pending register.

Behaviour:
- State: pending[NUM_HARTS][32] bit array, stall_cnt per hart, sb_err. Reset (async): all pending = 0, pending_any = 0, stall_cnt = 0, sb_err = 0.
- Register x0 is never pending, never forwarded, never causes a stall; a zero-rd issue sets nothing.
- Forwarding (combinational): a source matches port k if wb_valid[k] is set, wb_hart[k] equals iss_hart, wb_rd[k] equals the source, the source is nonzero and used. The lowest matching k drives fwd=1 and fwd_data=wb_data[k]; with no match, fwd=0 and data=0.
- Stall (combinational): iss_valid and any of:
  - a used rs is pending and not matched by a forwarding port;
  - iss_rd_we with nonzero rd whose pending bit is set and is not cleared by a wb_clr this cycle (WAW).
- Accept means iss_valid and not iss_stall.
- Set: accept, iss_long, iss_rd_we and rd nonzero set pending[iss_hart][iss_rd] at the next edge.
- Clear: wb_valid[k] and wb_clr[k] clear pending[wb_hart[k]][wb_rd[k]].
  - Clear of a non-pending nonzero register sets sb_err (sticky until reset).
  - Set and clear of the same bit in one cycle: set wins, bit stays 1.
- Two wb ports clearing the same bit in one cycle: cleared once, no error.
- Forwarding from a port with wb_clr=0 (ALU writeback) does not touch pending.
- pending_any[h] is the registered OR-reduce of the next-state pending[h]; it updates on the same edge as the bits.
- stall_cnt[iss_hart] increments by 1 each cycle iss_stall=1 and saturates at all-ones.
- Reset asserted mid-operation drops all pending state immediately. Later wb_clr of those registers raises sb_err; this is intentional, and the core is reset as a whole.

Decomposition:
- Shared package/defines: `XLEN, `REG_ADDR_W, `HART_ID_W (existing), plus a new SB_WB_ALU=0 / SB_WB_MULDIV=1 port-index constant.
- One sub-module is natural: hazard_fwd_mux, a parametrised priority match/select for one source operand, instantiated twice.

Test Plan:
- Reset, then issue addi x1 (short, hart0) -> no stall; pending_any=00; stall_cnt all 0.
- Issue lw x6 (long, hart0), then add x7,x6,x1 next cycle with no writeback -> iss_stall=1 each cycle, stall_cnt[0] increments. wb port0 valid/clr, rd=6, data=21 -> rs1_fwd=1, rs1_fwd_data=21, stall=0, pending[0][6] cleared.
- Hart1 issues muldiv to x3 (long); hart0 reads x3 -> no stall; pending_any=10.
- Port0 and port1 both write hart0 x5 with data 7 and 9 in the same cycle -> rs1_fwd_data=7 (port0 priority).
- wb_clr to hart0 x9 with nothing pending -> sb_err=1 next cycle, stays 1. Same-cycle issue-long rd=4 plus clear of pending x4 -> pending remains 1.
- Force stall_cnt[0] to near all-ones (CNT_W=4 build: 14), stall 3 cycles -> reads 15 and holds. Assert rst_n mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and constants for the per-hart register scoreboard.
// The hart-id width is sized for the default two-hart core.
package hazard_scoreboard_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int HART_ID_W  = 1;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Writeback port indices; a lower index has higher forwarding priority.
  localparam int SB_WB_ALU    = 0;
  localparam int SB_WB_MULDIV = 1;
endpackage

// File: rtl/hazard_fwd_mux.sv
// Priority match/select of same-cycle writeback data for one source operand.
// The lowest-numbered matching writeback port supplies the data.
module hazard_fwd_mux
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_WB = 2
) (
  input  logic [REG_ADDR_W-1:0]        i_src,
  input  logic                         i_src_used,
  input  logic [HART_ID_W-1:0]         i_hart,
  input  logic [NUM_WB-1:0]            i_wb_valid,
  input  logic [NUM_WB*HART_ID_W-1:0]  i_wb_hart,
  input  logic [NUM_WB*REG_ADDR_W-1:0] i_wb_rd,
  input  logic [NUM_WB*XLEN-1:0]       i_wb_data,
  output logic                         o_fwd,
  output logic [XLEN-1:0]              o_fwd_data
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_fwd      = 1'b0;
    o_fwd_data = '0;
    if (i_src_used && (i_src != '0)) begin
      // Walk from the highest port down so the lowest match is the one that sticks.
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (i_wb_valid[k] &&
            (i_wb_hart[k*HART_ID_W +: HART_ID_W] == i_hart) &&
            (i_wb_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_src)) begin
          o_fwd      = 1'b1;
          o_fwd_data = i_wb_data[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-hart pending-register scoreboard: stalls dependent issue, forwards
// same-cycle writeback results, counts stall cycles and flags stray clears.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int NUM_WB    = 2,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iss_valid,
  input  logic [HART_ID_W-1:0]         iss_hart,
  input  logic [REG_ADDR_W-1:0]        iss_rs1,
  input  logic [REG_ADDR_W-1:0]        iss_rs2,
  input  logic                         iss_rs1_used,
  input  logic                         iss_rs2_used,
  input  logic [REG_ADDR_W-1:0]        iss_rd,
  input  logic                         iss_rd_we,
  input  logic                         iss_long,
  output logic                         iss_stall,
  output logic                         rs1_fwd,
  output logic                         rs2_fwd,
  output logic [XLEN-1:0]              rs1_fwd_data,
  output logic [XLEN-1:0]              rs2_fwd_data,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB-1:0]            wb_clr,
  input  logic [NUM_WB*HART_ID_W-1:0]  wb_hart,
  input  logic [NUM_WB*REG_ADDR_W-1:0] wb_rd,
  input  logic [NUM_WB*XLEN-1:0]       wb_data,
  output logic [NUM_HARTS-1:0]         pending_any,
  output logic [NUM_HARTS*CNT_W-1:0]   stall_cnt,
  output logic                         sb_err
);

  logic [NUM_REGS-1:0]   r_pending   [NUM_HARTS];
  logic [NUM_REGS-1:0]   w_pend_nxt  [NUM_HARTS];
  logic [NUM_HARTS-1:0]  r_pending_any;
  logic [CNT_W-1:0]      r_stall_cnt [NUM_HARTS];
  logic                  r_sb_err;

  logic [HART_ID_W-1:0]  w_wb_hart [NUM_WB];
  logic [REG_ADDR_W-1:0] w_wb_rd   [NUM_WB];
  logic                  w_wb_clr  [NUM_WB];
  logic                  w_rs1_blk, w_rs2_blk, w_rd_cleared, w_waw, w_accept, w_err_set;

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_unpack
    assign w_wb_hart[k] = wb_hart[k*HART_ID_W +: HART_ID_W];
    assign w_wb_rd[k]   = wb_rd[k*REG_ADDR_W +: REG_ADDR_W];
    assign w_wb_clr[k]  = wb_valid[k] && wb_clr[k];
  end

  hazard_fwd_mux #(.NUM_WB(NUM_WB)) u_rs1_mux (
    .i_src      (iss_rs1),
    .i_src_used (iss_rs1_used),
    .i_hart     (iss_hart),
    .i_wb_valid (wb_valid),
    .i_wb_hart  (wb_hart),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_fwd      (rs1_fwd),
    .o_fwd_data (rs1_fwd_data)
  );

  hazard_fwd_mux #(.NUM_WB(NUM_WB)) u_rs2_mux (
    .i_src      (iss_rs2),
    .i_src_used (iss_rs2_used),
    .i_hart     (iss_hart),
    .i_wb_valid (wb_valid),
    .i_wb_hart  (wb_hart),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_fwd      (rs2_fwd),
    .o_fwd_data (rs2_fwd_data)
  );

  // A pending source is harmless when a writeback port delivers it this cycle.
  always_comb begin
    w_rd_cleared = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (w_wb_clr[k] && (w_wb_hart[k] == iss_hart) && (w_wb_rd[k] == iss_rd))
        w_rd_cleared = 1'b1;
    end
    w_rs1_blk = iss_rs1_used && (iss_rs1 != '0) && r_pending[iss_hart][iss_rs1] && !rs1_fwd;
    w_rs2_blk = iss_rs2_used && (iss_rs2 != '0) && r_pending[iss_hart][iss_rs2] && !rs2_fwd;
    w_waw     = iss_rd_we && (iss_rd != '0) && r_pending[iss_hart][iss_rd] && !w_rd_cleared;
    iss_stall = iss_valid && (w_rs1_blk || w_rs2_blk || w_waw);
    w_accept  = iss_valid && !iss_stall;
  end

  // Clears are applied first so a same-cycle set of the same bit wins.
  always_comb begin
    w_pend_nxt = r_pending;
    w_err_set  = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (w_wb_clr[k] && (w_wb_rd[k] != '0)) begin
        if (!r_pending[w_wb_hart[k]][w_wb_rd[k]])
          w_err_set = 1'b1;
        w_pend_nxt[w_wb_hart[k]][w_wb_rd[k]] = 1'b0;
      end
    end
    if (w_accept && iss_long && iss_rd_we && (iss_rd != '0))
      w_pend_nxt[iss_hart][iss_rd] = 1'b1;
  end

  // NOTE: the pending array is small flop state that must read empty after reset, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_pending[h]   <= '0;
        r_stall_cnt[h] <= '0;
      end
      r_pending_any <= '0;
      r_sb_err      <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
      r_pending <= w_pend_nxt;
      for (int h = 0; h < NUM_HARTS; h++)
        r_pending_any[h] <= |w_pend_nxt[h];
      if (w_err_set)
        r_sb_err <= 1'b1;
      if (iss_stall && (r_stall_cnt[iss_hart] != '1))
        r_stall_cnt[iss_hart] <= r_stall_cnt[iss_hart] + CNT_W'(1);
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_cnt_flat
    assign stall_cnt[h*CNT_W +: CNT_W] = r_stall_cnt[h];
  end

  assign pending_any = r_pending_any;
  assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, randomized
// traffic against a behavioural model, counter saturation and async reset.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NH  = 2;
  localparam int NW  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic            clk, rst_n;
  logic            iss_valid, iss_hart, iss_rs1_used, iss_rs2_used, iss_rd_we, iss_long;
  logic [4:0]      iss_rs1, iss_rs2, iss_rd;
  logic            iss_stall, rs1_fwd, rs2_fwd;
  logic [31:0]     rs1_fwd_data, rs2_fwd_data;
  logic [NW-1:0]   wb_valid, wb_clr;
  logic [NW-1:0]   wb_hart;
  logic [NW*5-1:0] wb_rd;
  logic [NW*32-1:0] wb_data;
  logic [NH-1:0]   pending_any;
  logic [NH*CW-1:0] stall_cnt;
  logic            sb_err;

  hazard_scoreboard #(.NUM_HARTS(NH), .NUM_WB(NW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_hart(iss_hart), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used), .iss_rd(iss_rd),
    .iss_rd_we(iss_rd_we), .iss_long(iss_long), .iss_stall(iss_stall),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .wb_valid(wb_valid), .wb_clr(wb_clr), .wb_hart(wb_hart), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending_any(pending_any), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic h; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic lng;
    logic [1:0] wbv; logic [1:0] wbc; logic [1:0] wbh;
    logic [4:0] wrd0; logic [4:0] wrd1; logic [31:0] wd0; logic [31:0] wd1;
    logic e_stall; logic e_f1; logic [31:0] e_d1; logic e_f2; logic [31:0] e_d2;
    logic [1:0] e_pany; logic e_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a plain table of which (hart, register) pairs await writeback.
  bit m_pend [NH][32];
  int m_cnt  [NH];
  bit m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      m_cnt[h] = 0;
      for (int r = 0; r < 32; r++) m_pend[h][r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_fwd(input vec_t x, input logic [4:0] s, input logic u,
                           output logic f, output logic [31:0] d);
    logic [4:0]  prd [2];
    logic [31:0] pdt [2];
    prd[0] = x.wrd0; prd[1] = x.wrd1;
    pdt[0] = x.wd0;  pdt[1] = x.wd1;
    f = 1'b0; d = '0;
    for (int k = 0; k < NW; k++) begin
      if (!f && u && s != 0 && x.wbv[k] && x.wbh[k] == x.h && prd[k] == s) begin
        f = 1'b1; d = pdt[k];
      end
    end
  endtask

  task automatic model_step(inout vec_t x);
    logic [4:0] prd [2];
    bit np [NH][32];
    logic f1, f2;
    logic [31:0] d1, d2;
    bit cl, blk;
    prd[0] = x.wrd0; prd[1] = x.wrd1;
    model_fwd(x, x.rs1, x.u1, f1, d1);
    model_fwd(x, x.rs2, x.u2, f2, d2);
    x.e_f1 = f1; x.e_d1 = d1; x.e_f2 = f2; x.e_d2 = d2;
    cl = 1'b0;
    for (int k = 0; k < NW; k++)
      if (x.wbv[k] && x.wbc[k] && x.wbh[k] == x.h && prd[k] == x.rd) cl = 1'b1;
    blk = (x.u1 && x.rs1 != 0 && m_pend[x.h][x.rs1] && !f1) ||
          (x.u2 && x.rs2 != 0 && m_pend[x.h][x.rs2] && !f2) ||
          (x.we && x.rd != 0 && m_pend[x.h][x.rd] && !cl);
    x.e_stall = x.v && blk;
    np = m_pend;
    for (int k = 0; k < NW; k++) begin
      if (x.wbv[k] && x.wbc[k] && prd[k] != 0) begin
        if (!m_pend[x.wbh[k]][prd[k]]) m_err = 1'b1;
        np[x.wbh[k]][prd[k]] = 1'b0;
      end
    end
    if (x.v && !x.e_stall && x.lng && x.we && x.rd != 0) np[x.h][x.rd] = 1'b1;
    if (x.e_stall && m_cnt[x.h] < SAT) m_cnt[x.h]++;
    m_pend = np;
    x.e_pany = '0;
    for (int h = 0; h < NH; h++)
      for (int r = 0; r < 32; r++)
        if (m_pend[h][r]) x.e_pany[h] = 1'b1;
    x.e_err = m_err;
  endtask

  task automatic drive(input vec_t x);
    iss_valid = x.v; iss_hart = x.h; iss_rs1 = x.rs1; iss_rs1_used = x.u1;
    iss_rs2 = x.rs2; iss_rs2_used = x.u2; iss_rd = x.rd; iss_rd_we = x.we; iss_long = x.lng;
    wb_valid = x.wbv; wb_clr = x.wbc; wb_hart = x.wbh;
    wb_rd = {x.wrd1, x.wrd0}; wb_data = {x.wd1, x.wd0};
  endtask

  function automatic vec_t idle_vec();
    vec_t x;
    x = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
    return x;
  endfunction

  // One cycle: drive at the falling edge, check combinational outputs, then registered ones after the rising edge.
  task automatic run(input vec_t xin, input bit use_model, input string tag);
    vec_t m, x;
    m = xin;
    model_step(m);
    x = use_model ? m : xin;
    @(negedge clk);
    drive(x);
    #1;
    check({tag, ".stall"}, 64'(iss_stall), 64'(x.e_stall));
    check({tag, ".rs1_fwd"}, 64'({rs1_fwd, rs1_fwd_data}), 64'({x.e_f1, x.e_d1}));
    check({tag, ".rs2_fwd"}, 64'({rs2_fwd, rs2_fwd_data}), 64'({x.e_f2, x.e_d2}));
    @(posedge clk);
    #1;
    check({tag, ".pending_any"}, 64'(pending_any), 64'(x.e_pany));
    check({tag, ".sb_err"}, 64'(sb_err), 64'(x.e_err));
    for (int h = 0; h < NH; h++)
      check($sformatf("%s.stall_cnt%0d", tag, h), 64'(stall_cnt[h*CW +: CW]), 64'(m_cnt[h]));
  endtask

  task automatic do_reset(input string tag);
    drive(idle_vec());
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".rst_pending_any"}, 64'(pending_any), 64'd0);
    check({tag, ".rst_stall_cnt"}, 64'(stall_cnt), 64'd0);
    check({tag, ".rst_sb_err"}, 64'(sb_err), 64'd0);
    check({tag, ".rst_stall"}, 64'(iss_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [19];
  vec_t rv, sv;

  initial begin
    rst_n = 1'b1;
    drive(idle_vec());
    #2;

    //         v h rs1 u1 rs2 u2 rd we lng | wbv   wbc   wbh  wrd0 wrd1 wd0 wd1 | stall f1 d1 f2 d2 pany err
    tbl[0]  = '{1,0,0,0,0,0,1,1,0,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b00,0};
    tbl[1]  = '{1,0,1,1,0,0,6,1,1,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b01,0};
    tbl[2]  = '{1,0,6,1,1,1,7,1,0,  2'b00,2'b00,2'b00,0,0,0,0,        1,0,0,0,0,2'b01,0};
    tbl[3]  = '{1,0,6,1,1,1,7,1,0,  2'b00,2'b00,2'b00,0,0,0,0,        1,0,0,0,0,2'b01,0};
    tbl[4]  = '{1,0,6,1,1,1,7,1,0,  2'b01,2'b01,2'b00,6,0,21,0,       0,1,21,0,0,2'b00,0};
    tbl[5]  = '{1,1,0,0,0,0,3,1,1,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b10,0};
    tbl[6]  = '{1,0,3,1,0,0,8,1,0,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b10,0};
    tbl[7]  = '{1,0,5,1,5,1,0,0,0,  2'b11,2'b00,2'b00,5,5,7,9,        0,1,7,1,7,2'b10,0};
    tbl[8]  = '{1,0,0,0,0,0,4,1,1,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b11,0};
    tbl[9]  = '{1,0,0,0,0,0,4,1,1,  2'b10,2'b10,2'b00,0,4,0,32'h55,   0,0,0,0,0,2'b11,0};
    tbl[10] = '{1,0,4,1,0,0,10,1,0, 2'b00,2'b00,2'b00,0,0,0,0,        1,0,0,0,0,2'b11,0};
    tbl[11] = '{0,0,0,0,0,0,0,0,0,  2'b11,2'b11,2'b00,4,4,1,2,        0,0,0,0,0,2'b10,0};
    tbl[12] = '{0,0,0,0,0,0,0,0,0,  2'b01,2'b01,2'b00,9,0,0,0,        0,0,0,0,0,2'b10,1};
    tbl[13] = '{0,0,0,0,0,0,0,0,0,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b10,1};
    tbl[14] = '{1,1,0,0,0,0,3,1,0,  2'b00,2'b00,2'b00,0,0,0,0,        1,0,0,0,0,2'b10,1};
    tbl[15] = '{1,1,0,0,0,0,3,1,0,  2'b01,2'b01,2'b01,3,0,0,0,        0,0,0,0,0,2'b00,1};
    tbl[16] = '{1,0,0,0,0,0,0,1,1,  2'b00,2'b00,2'b00,0,0,0,0,        0,0,0,0,0,2'b00,1};
    tbl[17] = '{1,0,0,1,0,0,0,0,0,  2'b01,2'b00,2'b00,0,0,5,0,        0,0,0,0,0,2'b00,1};
    tbl[18] = '{1,0,5,1,5,0,0,0,0,  2'b11,2'b00,2'b01,5,5,3,4,        0,1,4,0,0,2'b00,1};

    do_reset("init");
    for (int i = 0; i < 19; i++) run(tbl[i], 1'b0, $sformatf("row%0d", i));

    // Randomized traffic over a small register window so hazards are frequent.
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      rv = idle_vec();
      rv.v = 1'($urandom_range(0, 1)); rv.h = 1'($urandom_range(0, 1));
      rv.rs1 = 5'($urandom_range(0, 7)); rv.u1 = 1'($urandom_range(0, 1));
      rv.rs2 = 5'($urandom_range(0, 7)); rv.u2 = 1'($urandom_range(0, 1));
      rv.rd = 5'($urandom_range(0, 7)); rv.we = 1'($urandom_range(0, 1));
      rv.lng = ($urandom_range(0, 2) == 0);
      rv.wbv = 2'($urandom_range(0, 3)); rv.wbh = 2'($urandom_range(0, 3));
      rv.wbc[SB_WB_ALU] = ($urandom_range(0, 3) == 0);
      rv.wbc[SB_WB_MULDIV] = ($urandom_range(0, 3) == 0);
      rv.wrd0 = 5'($urandom_range(0, 7)); rv.wrd1 = 5'($urandom_range(0, 7));
      rv.wd0 = $urandom; rv.wd1 = $urandom;
      run(rv, 1'b1, $sformatf("rnd%0d", i));
    end

    // Counter saturation: park hart0 on a pending load far past the counter range.
    do_reset("sat");
    sv = idle_vec();
    sv.v = 1; sv.rd = 6; sv.we = 1; sv.lng = 1;
    run(sv, 1'b1, "sat_lw");
    sv = idle_vec();
    sv.v = 1; sv.rs1 = 6; sv.u1 = 1; sv.rd = 7; sv.we = 1;
    for (int i = 0; i < SAT + 3; i++) run(sv, 1'b1, $sformatf("sat%0d", i));
    check("sat_cnt0", 64'(stall_cnt[CW-1:0]), 64'(SAT));
    check("sat_cnt1", 64'(stall_cnt[2*CW-1:CW]), 64'd0);

    // Reset in the middle of a stall cycle takes effect without a clock edge.
    @(negedge clk);
    drive(sv);
    #1;
    check("midrst_pre_stall", 64'(iss_stall), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 64'(iss_stall), 64'd0);
    check("midrst_pending_any", 64'(pending_any), 64'd0);
    check("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("midrst_sb_err", 64'(sb_err), 64'd0);
    check("midrst_fwd", 64'({rs1_fwd, rs2_fwd}), 64'd0);
    drive(idle_vec());
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
